hawk_att_lkup: RTL and testbench

Address-translation lookup stage between the CPU-request front end and the HAWK compression unit. It accepts an `att_lkup_reqpkt_t` for a host physical page (HPPA) and fetches the 64B ATT cache line holding that page's 8B `AttEntry` over the AXI read master. It then decodes the entry and presents a `trnsl_reqpkt_t` (PPA, status, allow_access, zero-page update) to the downstream page manager. One lookup is in flight at a time.

---
 rtl/hawk_att_lkup.sv | 261 ++++++++++++++++++++++++++
 tb/tb_hawk_att_lkup.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_att_lkup.sv
// HAWK ATT lookup stage: hppa -> ATT line fetch over AXI -> decoded translation result.
// Define HAWK_ATT_LINE_CACHE_EN to enable the one-line ATT cache.

package hawk_att_pkg;
    localparam logic [63:0] HAWK_ATT_START = 64'h0000_0000_4000_0000;
    localparam logic [63:0] HPPA_BASE_ADDR = 64'h0000_0001_0000_0000;
    localparam logic [63:0] ATT_ENTRY_CNT  = 64'd4096;

    localparam logic [1:0] STS_DALLOC = 2'b00;
    localparam logic [1:0] STS_UNCOMP = 2'b01;
    localparam logic [1:0] STS_COMP   = 2'b10;
    localparam logic [1:0] STS_INCOMP = 2'b11;

    typedef struct packed {
        logic [7:0]  zpd_cnt;
        logic [43:0] way;
        logic [9:0]  rsvd;
        logic [1:0]  sts;
    } AttEntry;

    typedef struct packed {
        logic        lookup;
        logic [51:0] hppa;
        logic        zeroBlkWr;
    } att_lkup_reqpkt_t;

    typedef struct packed {
        logic        arvalid;
        logic [63:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic arready;
    } axi_rd_rdypkt_t;

    typedef struct packed {
        logic         rvalid;
        logic [511:0] rdata;
        logic [1:0]   rresp;
        logic         rlast;
    } axi_rd_resppkt_t;

    typedef struct packed {
        logic [63:0] ppa;
        logic [1:0]  sts;
        logic        allow_access;
        logic        zpd_update;
        logic [7:0]  zpd_cnt;
    } trnsl_reqpkt_t;

    // ATT entries are stored big-endian; reverse the bytes inside every 8B word.
    function automatic logic [511:0] get_8byte_byteswap(input logic [511:0] line);
        logic [511:0] sw;
        sw = '0;
        for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < 8; b++) begin
                sw[64*w + 8*b +: 8] = line[64*w + 8*(7-b) +: 8];
            end
        end
        return sw;
    endfunction
endpackage

module hawk_att_lkup
    import hawk_att_pkg::*;
#(
    parameter logic [63:0] ATT_BASE  = HAWK_ATT_START,
    parameter logic [63:0] HPPA_BASE = HPPA_BASE_ADDR,
    parameter logic [63:0] ENTRY_CNT = ATT_ENTRY_CNT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  att_lkup_reqpkt_t lkup_req_i,
    output logic             lkup_ready_o,
    output axi_rd_reqpkt_t   rd_req_o,
    input  axi_rd_rdypkt_t   rd_rdy_i,
    input  axi_rd_resppkt_t  rd_resp_i,
    output trnsl_reqpkt_t    trnsl_o,
    output logic             trnsl_valid_o,
    input  logic             trnsl_ready_i,
    input  logic             att_upd_i,
    output logic             lkup_err_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;

    logic [63:0]   r_line_addr;
    logic [2:0]    r_slot;
    logic          r_zero_wr;
    trnsl_reqpkt_t r_trnsl;

    logic [63:0]   w_byte_addr;
    logic [63:0]   w_off;
    logic [63:0]   w_idx;
    logic [63:0]   w_line_addr;
    logic          w_unmanaged;
    logic          w_accept;
    logic          w_hit;
    logic          w_beat;
    logic          w_beat_err;
    logic [511:0]  w_line_sw;
    logic [511:0]  w_line_sel;
    logic [2:0]    w_slot;
    logic          w_zero;
    AttEntry       w_entry;
    trnsl_reqpkt_t w_line_res;
    trnsl_reqpkt_t w_unmgd_res;
    logic [9:0]    w_unused_rsvd;

    function automatic trnsl_reqpkt_t decode(input logic [7:0]  zpd,
                                             input logic [43:0] way,
                                             input logic [1:0]  sts,
                                             input logic        zw,
                                             input logic        err);
        trnsl_reqpkt_t t;
        t.ppa          = {8'h00, way, 12'h000};
        t.sts          = err ? STS_DALLOC : sts;
        t.allow_access = !err && (sts == STS_UNCOMP);
        t.zpd_update   = !err && zw && (sts == STS_UNCOMP);
        t.zpd_cnt      = (t.zpd_update && (zpd != 8'hFF)) ? zpd + 8'd1 : zpd;
        return t;
    endfunction

    assign w_byte_addr = {lkup_req_i.hppa, 12'h000};
    assign w_off       = w_byte_addr - HPPA_BASE;
    assign w_idx       = w_off >> 12;
    assign w_unmanaged = (w_byte_addr < HPPA_BASE) || (w_idx >= ENTRY_CNT);
    assign w_line_addr = ATT_BASE + ((w_idx >> 3) << 6);
    assign w_accept    = (r_state == ST_IDLE) && lkup_req_i.lookup;

    assign w_beat      = (r_state == ST_R) && rd_resp_i.rvalid;
    assign w_beat_err  = w_beat && ((rd_resp_i.rresp != 2'b00) || !rd_resp_i.rlast);
    assign lkup_err_o  = w_beat_err;
    assign w_line_sw   = get_8byte_byteswap(rd_resp_i.rdata);

`ifdef HAWK_ATT_LINE_CACHE_EN
    logic         r_cache_vld;
    logic [63:0]  r_cache_addr;
    logic [511:0] r_cache_data;

    // A rewrite in the same cycle as the lookup must not be served stale data.
    assign w_hit      = r_cache_vld && !att_upd_i && (r_cache_addr == w_line_addr);
    assign w_line_sel = (r_state == ST_IDLE) ? r_cache_data : w_line_sw;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cache_vld  <= 1'b0;
            r_cache_addr <= '0;
            r_cache_data <= '0;
        end else if (att_upd_i) begin
            r_cache_vld  <= 1'b0;
        end else if (w_beat && !w_beat_err) begin
            r_cache_vld  <= 1'b1;
            r_cache_addr <= r_line_addr;
            r_cache_data <= w_line_sw;
        end
    end
`else
    logic w_unused_upd;

    assign w_hit        = 1'b0;
    assign w_line_sel   = w_line_sw;
    assign w_unused_upd = att_upd_i;
`endif

    // In IDLE the entry comes from the cached line for the incoming request.
    assign w_slot        = (r_state == ST_IDLE) ? w_idx[2:0] : r_slot;
    assign w_zero        = (r_state == ST_IDLE) ? lkup_req_i.zeroBlkWr : r_zero_wr;
    assign w_entry       = AttEntry'(w_line_sel[64*w_slot +: 64]);
    assign w_unused_rsvd = w_entry.rsvd;
    assign w_line_res    = decode(w_entry.zpd_cnt, w_entry.way, w_entry.sts, w_zero, w_beat_err);

    always_comb begin
        w_unmgd_res              = '0;
        w_unmgd_res.ppa          = w_byte_addr;
        w_unmgd_res.sts          = STS_UNCOMP;
        w_unmgd_res.allow_access = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        lkup_ready_o  = 1'b0;
        trnsl_valid_o = 1'b0;
        rd_req_o      = '0;
        case (r_state)
            ST_IDLE: begin
                lkup_ready_o = 1'b1;
                if (lkup_req_i.lookup) begin
                    w_state_nxt = (w_unmanaged || w_hit) ? ST_RESP : ST_AR;
                end
            end
            ST_AR: begin
                rd_req_o.arvalid = 1'b1;
                rd_req_o.araddr  = r_line_addr;
                rd_req_o.arlen   = 8'd0;
                rd_req_o.arsize  = 3'd6;
                rd_req_o.arburst = 2'b01;
                if (rd_rdy_i.arready) begin
                    w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                rd_req_o.rready = 1'b1;
                if (rd_resp_i.rvalid) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                trnsl_valid_o = 1'b1;
                if (trnsl_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_line_addr <= '0;
            r_slot      <= '0;
            r_zero_wr   <= 1'b0;
            r_trnsl     <= '0;
        end else begin
            if (w_accept) begin
                r_line_addr <= w_line_addr;
                r_slot      <= w_idx[2:0];
                r_zero_wr   <= lkup_req_i.zeroBlkWr;
                if (w_unmanaged) begin
                    r_trnsl <= w_unmgd_res;
                end else if (w_hit) begin
                    r_trnsl <= w_line_res;
                end
            end
            if (w_beat) begin
                r_trnsl <= w_line_res;
            end
        end
    end

    assign trnsl_o = r_trnsl;
endmodule

// File: tb/tb_hawk_att_lkup.sv
// Bench for hawk_att_lkup: directed test-plan cases plus randomized lookups against a behavioural model.
`timescale 1ns/1ps
module tb_hawk_att_lkup;
    import hawk_att_pkg::*;

    localparam logic [63:0] ATT_B = HAWK_ATT_START;
    localparam logic [63:0] HB    = HPPA_BASE_ADDR;
    localparam logic [63:0] EC    = ATT_ENTRY_CNT;
    localparam int          ECI   = int'(ATT_ENTRY_CNT);
    localparam logic [51:0] HP0   = 52'(HPPA_BASE_ADDR >> 12);
    localparam int          TW    = $bits(trnsl_reqpkt_t);

    logic             clk_i = 1'b0;
    logic             rst_ni;
    att_lkup_reqpkt_t lkup_req_i;
    logic             lkup_ready_o;
    axi_rd_reqpkt_t   rd_req_o;
    axi_rd_rdypkt_t   rd_rdy_i;
    axi_rd_resppkt_t  rd_resp_i;
    trnsl_reqpkt_t    trnsl_o;
    logic             trnsl_valid_o;
    logic             trnsl_ready_i;
    logic             att_upd_i;
    logic             lkup_err_o;

    hawk_att_lkup dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .lkup_req_i    (lkup_req_i),
        .lkup_ready_o  (lkup_ready_o),
        .rd_req_o      (rd_req_o),
        .rd_rdy_i      (rd_rdy_i),
        .rd_resp_i     (rd_resp_i),
        .trnsl_o       (trnsl_o),
        .trnsl_valid_o (trnsl_valid_o),
        .trnsl_ready_i (trnsl_ready_i),
        .att_upd_i     (att_upd_i),
        .lkup_err_o    (lkup_err_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [TW-1:0] exp_q[$];
    trnsl_reqpkt_t last_trnsl;
    logic [63:0]   last_araddr;
    int            ar_cnt   = 0;
    int            err_cnt  = 0;
    logic [63:0]   att_mem [ECI];
    logic          cache_vld;
    logic [63:0]   cache_line;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process: every cycle the result is valid it must equal the queue head.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && trnsl_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 128'(trnsl_valid_o), 128'd0);
            end else begin
                chk("trnsl", 128'(trnsl_o), 128'(exp_q[0]));
                if (trnsl_ready_i) begin
                    last_trnsl = trnsl_o;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && rd_req_o.arvalid && rd_rdy_i.arready) ar_cnt++;
        if (rst_ni === 1'b1 && lkup_err_o) err_cnt++;
    end

    // ---------------- behavioural model ----------------
    function automatic logic is_managed(input logic [51:0] hppa);
        logic [63:0] ba;
        ba = {hppa, 12'h000};
        if (ba < HB) return 1'b0;
        return ((ba - HB) / 64'd4096) < EC;
    endfunction

    function automatic trnsl_reqpkt_t model(input logic [51:0] hppa, input logic zw, input logic err);
        trnsl_reqpkt_t t;
        logic [63:0]   ba;
        logic [63:0]   ent;
        int            sts;
        int            zpd;
        ba = {hppa, 12'h000};
        t  = '0;
        if (!is_managed(hppa)) begin
            t.ppa          = ba;
            t.sts          = 2'b01;
            t.allow_access = 1'b1;
            return t;
        end
        ent = att_mem[int'((ba - HB) / 64'd4096)];
        sts = int'(ent % 64'd4);
        zpd = int'(ent / 64'h0100_0000_0000_0000);
        t.ppa          = ent & 64'h00FF_FFFF_FFFF_F000;
        t.sts          = err ? 2'b00 : 2'(sts);
        t.allow_access = !err && (sts == 1);
        t.zpd_update   = !err && zw && (sts == 1);
        if (t.zpd_update) zpd = (zpd == 255) ? 255 : zpd + 1;
        t.zpd_cnt      = 8'(zpd);
        return t;
    endfunction

    // Memory byte image of a 64B ATT line: each 8B entry stored most-significant byte first.
    function automatic logic [511:0] line_image(input int line_no);
        logic [511:0] img;
        logic [63:0]  e;
        img = '0;
        for (int a = 0; a < 64; a++) begin
            e = att_mem[line_no*8 + a/8];
            img[8*a +: 8] = e[8*(7 - a%8) +: 8];
        end
        return img;
    endfunction

    function automatic logic [63:0] rand_entry();
        logic [7:0]  zpd;
        logic [43:0] way;
        zpd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        way = {12'($urandom), 32'($urandom)};
        return {zpd, way, 10'($urandom), 2'($urandom_range(0, 3))};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pulse_upd();
        att_upd_i = 1'b1;
        @(posedge clk_i); #1;
        att_upd_i = 1'b0;
        cache_vld = 1'b0;
    endtask

    task automatic set_entry(input int idx, input logic [63:0] val);
        att_mem[idx] = val;
        pulse_upd();
    endtask

    task automatic lookup(input logic [51:0] hppa, input logic zw, input logic [1:0] rresp,
                          input logic no_last, input logic upd_on_beat,
                          input int ar_wait, input int r_wait, input int resp_wait);
        logic [63:0]   ba;
        logic [63:0]   line_addr;
        int            idx;
        logic          managed;
        logic          hit;
        logic          err;
        trnsl_reqpkt_t exp;
        ba        = {hppa, 12'h000};
        managed   = is_managed(hppa);
        idx       = managed ? int'((ba - HB) / 64'd4096) : 0;
        line_addr = ATT_B + 64'((idx / 8) * 64);
        hit       = 1'b0;
`ifdef HAWK_ATT_LINE_CACHE_EN
        hit = managed && cache_vld && (cache_line == line_addr);
`endif
        err = managed && !hit && ((rresp != 2'b00) || no_last);
        exp = model(hppa, zw, err);
        chk("ready_idle", 128'(lkup_ready_o), 128'd1);
        exp_q.push_back(exp);
        lkup_req_i.lookup    = 1'b1;
        lkup_req_i.hppa      = hppa;
        lkup_req_i.zeroBlkWr = zw;
        @(posedge clk_i); #1;
        lkup_req_i = '0;
        if (!managed || hit) begin
            chk("fast_valid", 128'(trnsl_valid_o), 128'd1);
            chk("fast_no_ar", 128'(rd_req_o.arvalid), 128'd0);
        end else begin
            chk("arvalid", 128'(rd_req_o.arvalid), 128'd1);
            chk("araddr", 128'(rd_req_o.araddr), 128'(line_addr));
            chk("arlen", 128'(rd_req_o.arlen), 128'd0);
            chk("ready_busy", 128'(lkup_ready_o), 128'd0);
            last_araddr = rd_req_o.araddr;
            repeat (ar_wait) begin
                @(posedge clk_i); #1;
                chk("ar_hold_valid", 128'(rd_req_o.arvalid), 128'd1);
                chk("ar_hold_addr", 128'(rd_req_o.araddr), 128'(line_addr));
            end
            rd_rdy_i.arready = 1'b1;
            @(posedge clk_i); #1;
            rd_rdy_i.arready = 1'b0;
            chk("rready", 128'(rd_req_o.rready), 128'd1);
            chk("ar_drop", 128'(rd_req_o.arvalid), 128'd0);
            repeat (r_wait) begin
                @(posedge clk_i); #1;
            end
            rd_resp_i.rvalid = 1'b1;
            rd_resp_i.rdata  = line_image(idx / 8);
            rd_resp_i.rresp  = rresp;
            rd_resp_i.rlast  = !no_last;
            att_upd_i        = upd_on_beat;
            #1;
            chk("lkup_err", 128'(lkup_err_o), 128'(err));
            @(posedge clk_i); #1;
            rd_resp_i = '0;
            att_upd_i = 1'b0;
            chk("valid_after_beat", 128'(trnsl_valid_o), 128'd1);
            chk("err_one_cycle", 128'(lkup_err_o), 128'd0);
            if (upd_on_beat) begin
                cache_vld = 1'b0;
            end else if (!err) begin
                cache_vld  = 1'b1;
                cache_line = line_addr;
            end
        end
        repeat (resp_wait) begin
            @(posedge clk_i); #1;
        end
        trnsl_ready_i = 1'b1;
        @(posedge clk_i); #1;
        trnsl_ready_i = 1'b0;
        chk("valid_drop", 128'(trnsl_valid_o), 128'd0);
        chk("ready_back", 128'(lkup_ready_o), 128'd1);
    endtask

    task automatic reset_in_r(input logic [51:0] hppa);
        lkup_req_i.lookup = 1'b1;
        lkup_req_i.hppa   = hppa;
        @(posedge clk_i); #1;
        lkup_req_i       = '0;
        rd_rdy_i.arready = 1'b1;
        @(posedge clk_i); #1;
        rd_rdy_i.arready = 1'b0;
        chk("rst_pre_rready", 128'(rd_req_o.rready), 128'd1);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_mid_ready", 128'(lkup_ready_o), 128'd1);
        chk("rst_mid_rdreq", 128'(rd_req_o), 128'd0);
        chk("rst_mid_valid", 128'(trnsl_valid_o), 128'd0);
        chk("rst_mid_trnsl", 128'(trnsl_o), 128'd0);
        chk("rst_mid_err", 128'(lkup_err_o), 128'd0);
        rst_ni    = 1'b1;
        cache_vld = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ar0;
        int e0;
        int r;
        logic [51:0] hp;
        lkup_req_i    = '0;
        rd_rdy_i      = '0;
        rd_resp_i     = '0;
        trnsl_ready_i = 1'b0;
        att_upd_i     = 1'b0;
        rst_ni        = 1'b0;
        cache_vld     = 1'b0;
        cache_line    = '0;
        last_trnsl    = '0;
        last_araddr   = '0;
        for (int i = 0; i < ECI; i++) att_mem[i] = 64'h0;
        for (int i = 0; i < 64; i++) att_mem[i] = rand_entry();

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ready", 128'(lkup_ready_o), 128'd1);
        chk("reset_rdreq", 128'(rd_req_o), 128'd0);
        chk("reset_trnsl", 128'(trnsl_o), 128'd0);
        chk("reset_valid", 128'(trnsl_valid_o), 128'd0);
        chk("reset_err", 128'(lkup_err_o), 128'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Miss, UNCOMP entry in slot 1 of the second line
        att_mem[9] = 64'h0300_0000_1234_5001;
        lookup(HP0 + 52'd9, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        chk("tp_araddr", 128'(last_araddr), 128'(ATT_B + 64'h40));
        chk("tp_ppa", 128'(last_trnsl.ppa), 128'h1234_5000);
        chk("tp_allow", 128'(last_trnsl.allow_access), 128'd1);
        chk("tp_zpd", 128'(last_trnsl.zpd_cnt), 128'h03);

        // Zero-block write saturates the counter
        set_entry(9, 64'hFF00_0000_1234_5001);
        lookup(HP0 + 52'd9, 1'b1, 2'b00, 1'b0, 1'b0, 1, 1, 1);
        chk("tp_sat_upd", 128'(last_trnsl.zpd_update), 128'd1);
        chk("tp_sat_cnt", 128'(last_trnsl.zpd_cnt), 128'hFF);

        // COMP entry denies access and suppresses the zero-page update
        set_entry(9, 64'h0300_0000_1234_5002);
        lookup(HP0 + 52'd9, 1'b1, 2'b00, 1'b0, 1'b0, 0, 2, 0);
        chk("tp_comp_allow", 128'(last_trnsl.allow_access), 128'd0);
        chk("tp_comp_upd", 128'(last_trnsl.zpd_update), 128'd0);
        chk("tp_comp_sts", 128'(last_trnsl.sts), 128'd2);

        // Unmanaged: first index past the table and a page below the base
        ar0 = ar_cnt;
        lookup(HP0 + 52'(EC), 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 2);
        chk("tp_unmgd_ppa", 128'(last_trnsl.ppa), 128'(HB + EC * 64'd4096));
        chk("tp_unmgd_allow", 128'(last_trnsl.allow_access), 128'd1);
        lookup(HP0 - 52'd1, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        chk("tp_below_ppa", 128'(last_trnsl.ppa), 128'(HB - 64'd4096));
        chk("tp_unmgd_no_ar", 128'(ar_cnt - ar0), 128'd0);

        // AXI error and missing rlast
        e0 = err_cnt;
        att_mem[17] = 64'h0500_0000_0ABC_D001;
        lookup(HP0 + 52'd17, 1'b1, 2'b10, 1'b0, 1'b0, 0, 1, 0);
        chk("tp_err_pulses", 128'(err_cnt - e0), 128'd1);
        chk("tp_err_sts", 128'(last_trnsl.sts), 128'd0);
        chk("tp_err_allow", 128'(last_trnsl.allow_access), 128'd0);
        lookup(HP0 + 52'd17, 1'b0, 2'b00, 1'b1, 1'b0, 0, 0, 0);
        chk("tp_nolast_allow", 128'(last_trnsl.allow_access), 128'd0);

        // Backpressure on both handshakes, then reset while waiting for R
        lookup(HP0 + 52'd20, 1'b0, 2'b00, 1'b0, 1'b0, 5, 0, 4);
        reset_in_r(HP0 + 52'd30);

        // Two slots of one line, then a rewrite between lookups
        pulse_upd();
        ar0 = ar_cnt;
        lookup(HP0 + 52'd40, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0);
        lookup(HP0 + 52'd47, 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0);
`ifdef HAWK_ATT_LINE_CACHE_EN
        chk("tp_cache_one_ar", 128'(ar_cnt - ar0), 128'd1);
`else
        chk("tp_cache_one_ar", 128'(ar_cnt - ar0), 128'd2);
`endif
        pulse_upd();
        lookup(HP0 + 52'd40, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0);
`ifdef HAWK_ATT_LINE_CACHE_EN
        chk("tp_cache_reread", 128'(ar_cnt - ar0), 128'd2);
`else
        chk("tp_cache_reread", 128'(ar_cnt - ar0), 128'd3);
`endif

        // Randomized lookups
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 5) == 0) set_entry($urandom_range(0, 31), rand_entry());
            r = $urandom_range(0, 9);
            if (r == 0)      hp = HP0 + 52'(EC) + 52'($urandom_range(0, 20));
            else if (r == 1) hp = HP0 - 52'd1 - 52'($urandom_range(0, 5));
            else             hp = HP0 + 52'($urandom_range(0, 31));
            lookup(hp, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation still running, required completion before 100000 cycles");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
